regfile_mp: RTL and testbench

Parametrised multi-read-port register file, the next generation of the processor's 32-bit regfile. It has NRD registered read ports and one write port, and reads and writes may occur in the same cycle. Register 0 is hardwired to zero. Reset triggers a sequenced one-entry-per-cycle clear with a busy indication, so the storage can map to RAM. It sits between decode (read addresses) and writeback (write port) in the datapath.

---
 rtl/regfile_mp.sv | 111 +++++++++++
 tb/tb_regfile_mp.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with sequenced clear
//
// Purpose: DEPTH x DWIDTH register file with NRD registered read ports and one
// write port. Register 0 always reads as zero and is never stored. Reset starts
// a clear sequence that writes zero to one entry per cycle, with busy asserted.
// This means the storage needs no reset and can map onto RAM.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   - write-first: a same-cycle read of the address being written returns wd
//   undefined - read-first: that read returns the old contents
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset; starts the clear sequence
//   re        per-port read enable                     [NRD]
//   ra        packed read addresses, port i at [i*AWIDTH +: AWIDTH]
//   rd        packed read data, port i at [i*DWIDTH +: DWIDTH]
//   rd_valid  per-port: rd slice was updated by the last edge
//   we/wa/wd  write enable, address, data
//   busy      clear sequence in progress; reads and writes are ignored
module regfile_mp #(
   parameter int AWIDTH = 6,
   parameter int DWIDTH = 32,
   parameter int NRD    = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NRD-1:0]         re,
   input  logic [NRD*AWIDTH-1:0]  ra,
   output logic [NRD*DWIDTH-1:0]  rd,
   output logic [NRD-1:0]         rd_valid,
   input  logic                   we,
   input  logic [AWIDTH-1:0]      wa,
   input  logic [DWIDTH-1:0]      wd,
   output logic                   busy
);
   localparam int DEPTH = 2**AWIDTH;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t              state;
   logic [AWIDTH-1:0]   clr_cnt;
   logic [DWIDTH-1:0]   mem [DEPTH];

   logic                run_write;
   logic                mem_we;
   logic [AWIDTH-1:0]   mem_wa;
   logic [DWIDTH-1:0]   mem_wd;
   logic [NRD*DWIDTH-1:0] rd_next;

   // Writes to entry 0 are dropped, so mem[0] is never stored and never read.
   assign run_write = (state == RUN) && we && (wa != '0);

   // The clear sequence and the functional write share the single write port.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = wa;
      mem_wd = wd;
      if (!rst) begin
         if (state == CLEAR) begin
            mem_we = 1'b1;
            mem_wa = clr_cnt;
            mem_wd = '0;
         end else if (run_write) begin
            mem_we = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

   always_comb begin
      rd_next = '0;
      for (int i = 0; i < NRD; i++) begin
         if (ra[i*AWIDTH +: AWIDTH] == '0) begin
            rd_next[i*DWIDTH +: DWIDTH] = '0;
`ifdef REGFILE_BYPASS_EN
         end else if (run_write && (ra[i*AWIDTH +: AWIDTH] == wa)) begin
            rd_next[i*DWIDTH +: DWIDTH] = wd;
`endif
         end else begin
            rd_next[i*DWIDTH +: DWIDTH] = mem[ra[i*AWIDTH +: AWIDTH]];
         end
      end
   end

   // Clear covers entries 1..DEPTH-1 only, so it takes DEPTH-1 cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= CLEAR;
         clr_cnt  <= AWIDTH'(1);
         busy     <= 1'b1;
         rd       <= '0;
         rd_valid <= '0;
      end else if (state == CLEAR) begin
         rd_valid <= '0;
         clr_cnt  <= clr_cnt + AWIDTH'(1);
         if (clr_cnt == AWIDTH'(DEPTH-1)) begin
            state <= RUN;
            busy  <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NRD; i++) begin
            if (re[i]) rd[i*DWIDTH +: DWIDTH] <= rd_next[i*DWIDTH +: DWIDTH];
         end
         rd_valid <= re;
      end
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized self-checking bench for regfile_mp
module tb_regfile_mp;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  re = '0;
   logic [11:0] ra = '0;
   logic [63:0] rd;
   logic [1:0]  rd_valid;
   logic        we = 1'b0;
   logic [5:0]  wa = '0;
   logic [31:0] wd = '0;
   logic        busy;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] model [64];
   logic [31:0] exp0, exp1;

   regfile_mp #(.AWIDTH(6), .DWIDTH(32), .NRD(2)) dut (
      .clk(clk), .rst(rst), .re(re), .ra(ra), .rd(rd), .rd_valid(rd_valid),
      .we(we), .wa(wa), .wd(wd), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Value a read of addr should return given the write happening in the same cycle.
   function automatic logic [31:0] model_read(input logic [5:0] addr, input logic w,
                                              input logic [5:0] a_w, input logic [31:0] d_w);
      if (addr == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (w && a_w != 0 && a_w == addr) return d_w;
`endif
      return model[addr];
   endfunction

   task automatic cycle(input logic w, input logic [5:0] a_w, input logic [31:0] d_w,
                        input logic [1:0] r, input logic [5:0] a0, input logic [5:0] a1);
      logic [31:0] e0, e1;
      we = w; wa = a_w; wd = d_w; re = r; ra = {a1, a0};
      e0 = model_read(a0, w, a_w, d_w);
      e1 = model_read(a1, w, a_w, d_w);
      @(posedge clk); #1;
      if (w && a_w != 0) model[a_w] = d_w;
      if (r[0]) exp0 = e0;
      if (r[1]) exp1 = e1;
      check("rd_valid", {62'b0, rd_valid}, {62'b0, r});
      check("rd0", {32'b0, rd[31:0]}, {32'b0, exp0});
      check("rd1", {32'b0, rd[63:32]}, {32'b0, exp1});
      check("busy_run", {63'b0, busy}, 64'd0);
      we = 1'b0; re = '0;
   endtask

   task automatic run_clear(input bit lockout, input int rst_at);
      int cnt;
      int again;
      again = rst_at;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_busy", {63'b0, busy}, 64'd1);
      check("rst_valid", {62'b0, rd_valid}, 64'd0);
      check("rst_rd", rd, 64'd0);
      if (lockout) begin
         we = 1'b1; wa = 6'd9; wd = 32'hAA; re = 2'b11; ra = {6'd9, 6'd9};
      end else begin
         we = 1'b0; re = '0;
      end
      cnt = 1;
      while (busy === 1'b1 && cnt < 200) begin
         if (again > 0 && cnt == again) begin
            again = 0;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check("mid_rst_busy", {63'b0, busy}, 64'd1);
            cnt = 1;
            continue;
         end
         @(posedge clk); #1;
         check("clr_valid", {62'b0, rd_valid}, 64'd0);
         check("clr_rd", rd, 64'd0);
         if (busy === 1'b1) cnt++;
      end
      check("busy_cycles", 64'(cnt), 64'd63);
      check("busy_done", {63'b0, busy}, 64'd0);
      we = 1'b0; re = '0;
      for (int i = 0; i < 64; i++) model[i] = 32'h0;
      exp0 = '0; exp1 = '0;
   endtask

   initial begin
      // Reset/clear, then every address reads zero
      run_clear(1'b0, 0);
      for (int a = 0; a < 64; a++) cycle(1'b0, 6'd0, 32'h0, 2'b11, 6'(a), 6'(63 - a));

      // Write/read
      cycle(1'b1, 6'd5, 32'hDEADBEEF, 2'b00, 6'd0, 6'd0);
      cycle(1'b1, 6'd63, 32'h12345678, 2'b00, 6'd0, 6'd0);
      cycle(1'b0, 6'd0, 32'h0, 2'b11, 6'd5, 6'd63);
      check("r5", {32'b0, rd[31:0]}, 64'hDEADBEEF);
      check("r63", {32'b0, rd[63:32]}, 64'h12345678);

      // Register 0 is hardwired to zero
      cycle(1'b1, 6'd0, 32'hFFFFFFFF, 2'b00, 6'd0, 6'd0);
      cycle(1'b0, 6'd0, 32'h0, 2'b11, 6'd0, 6'd0);
      check("r0_p0", {32'b0, rd[31:0]}, 64'd0);
      check("r0_p1", {32'b0, rd[63:32]}, 64'd0);

      // Same-cycle collision
      cycle(1'b1, 6'd7, 32'h1, 2'b00, 6'd0, 6'd0);
      cycle(1'b1, 6'd7, 32'h2, 2'b11, 6'd7, 6'd7);
`ifdef REGFILE_BYPASS_EN
      check("coll_p0", {32'b0, rd[31:0]}, 64'h2);
      check("coll_p1", {32'b0, rd[63:32]}, 64'h2);
`else
      check("coll_p0", {32'b0, rd[31:0]}, 64'h1);
      check("coll_p1", {32'b0, rd[63:32]}, 64'h1);
`endif
      cycle(1'b0, 6'd0, 32'h0, 2'b11, 6'd7, 6'd7);
      check("coll_reread", {32'b0, rd[31:0]}, 64'h2);

      // Read enable low holds data
      cycle(1'b0, 6'd0, 32'h0, 2'b00, 6'd5, 6'd5);
      check("hold_p0", {32'b0, rd[31:0]}, 64'h2);

      // Randomized traffic, small address range favoured to provoke collisions
      for (int n = 0; n < 400; n++) begin
         logic [5:0] aw, a0, a1;
         aw = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
         a0 = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
         a1 = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
         cycle(1'($urandom_range(0, 1)), aw, $urandom, 2'($urandom_range(0, 3)), a0, a1);
      end

      // Busy lockout
      run_clear(1'b1, 0);
      cycle(1'b0, 6'd0, 32'h0, 2'b11, 6'd9, 6'd9);
      check("lockout_r9", {32'b0, rd[31:0]}, 64'd0);

      // Reset mid-clear, then reset in RUN with reads active
      cycle(1'b1, 6'd3, 32'h55, 2'b00, 6'd0, 6'd0);
      run_clear(1'b0, 10);
      cycle(1'b1, 6'd3, 32'h55, 2'b00, 6'd0, 6'd0);
      re = 2'b11; ra = {6'd3, 6'd3};
      run_clear(1'b0, 0);
      cycle(1'b0, 6'd0, 32'h0, 2'b11, 6'd3, 6'd3);
      check("r3_cleared", {32'b0, rd[31:0]}, 64'd0);
      check("r3_cleared_p1", {32'b0, rd[63:32]}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
